multiplication_unit: RTL

//  Iterative radix-2 shift-add integer multiplier for the RV32M MUL/MULH/MULHSU/MULHU ops.

---
 rtl/multiplication_unit_pkg.sv | 20 ++
 rtl/multiplication_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/multiplication_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide units.
// - islem_t : operation select, equal to funct3[1:0]. The division unit uses
//             the same encodings for DIV/DIVU/REM/REMU.
// - durum_t : multiplier FSM states (idle, iterate, sign-fix).
package multiplication_unit_pkg;

  typedef enum logic [1:0] {
    ISLEM_MUL    = 2'b00,
    ISLEM_MULH   = 2'b01,
    ISLEM_MULHSU = 2'b10,
    ISLEM_MULHU  = 2'b11
  } islem_t;

  typedef enum logic [1:0] {
    BOS     = 2'b00,
    HESAPLA = 2'b01,
    DUZELT  = 2'b10
  } durum_t;

endpackage

// File: rtl/multiplication_unit.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes at accept time, multiplied unsigned over
// XLEN cycles, and the sign is re-applied in a final fix-up cycle. Latency is
// fixed: bitti_o pulses XLEN+2 cycles after the accept cycle.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset; aborts any operation in flight
//   basla_i     start request, honoured only while idle
//   islem_i     operation select (00 MUL, 01 MULH, 10 MULHSU, 11 MULHU)
//   carpilan_i  operand 1 (rs1), sampled only in the accept cycle
//   carpan_i    operand 2 (rs2), sampled only in the accept cycle
//   sonuc_o     registered result, held until the next result
//   bitti_o     one-cycle done pulse, sonuc_o valid in that cycle
//   mesgul_o    high while an operation is in progress
module multiplication_unit
  import multiplication_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            basla_i,
  input  logic [1:0]      islem_i,
  input  logic [XLEN-1:0] carpilan_i,
  input  logic [XLEN-1:0] carpan_i,
  output logic [XLEN-1:0] sonuc_o,
  output logic            bitti_o,
  output logic            mesgul_o
);

  localparam int CW = $clog2(XLEN);

  durum_t            durum, durum_next;
  islem_t            islem_q;
  logic [XLEN-1:0]   carpilan_q;
  logic [XLEN-1:0]   carpan_q;
  logic              isaret;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     sayac;

  logic              isaretli1, isaretli2, neg1, neg2;
  logic [XLEN-1:0]   abs1, abs2;
  logic [XLEN:0]     toplam;
  logic [2*XLEN-1:0] urun;

  // Operand conditioning. The magnitude of the most negative value fits in
  // XLEN unsigned bits, so no extra width is needed here.
  always_comb begin
    isaretli1 = (islem_t'(islem_i) != ISLEM_MULHU);
    isaretli2 = (islem_t'(islem_i) inside {ISLEM_MUL, ISLEM_MULH});
    neg1      = isaretli1 & carpilan_i[XLEN-1];
    neg2      = isaretli2 & carpan_i[XLEN-1];
    abs1      = neg1 ? (-carpilan_i) : carpilan_i;
    abs2      = neg2 ? (-carpan_i)   : carpan_i;
  end

  // One iteration: conditional add into the upper half with carry kept,
  // then {carry, acc, multiplier} shifts right by one.
  always_comb begin
    toplam = {1'b0, acc[2*XLEN-1:XLEN]} + (carpan_q[0] ? {1'b0, carpilan_q} : '0);
    urun   = isaret ? (-acc) : acc;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) durum <= BOS;
    else       durum <= durum_next;
  end

  always_comb begin
    durum_next = durum;
    case (durum)
      BOS:     if (basla_i) durum_next = HESAPLA;
      HESAPLA: if (sayac == '0) durum_next = DUZELT;
      DUZELT:  durum_next = BOS;
      default: durum_next = BOS;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      islem_q    <= ISLEM_MUL;
      carpilan_q <= '0;
      carpan_q   <= '0;
      isaret     <= 1'b0;
      acc        <= '0;
      sayac      <= '0;
      sonuc_o    <= '0;
      bitti_o    <= 1'b0;
    end else begin
      bitti_o <= 1'b0;
      case (durum)
        BOS: begin
          if (basla_i) begin
            islem_q    <= islem_t'(islem_i);
            carpilan_q <= abs1;
            carpan_q   <= abs2;
            isaret     <= neg1 ^ neg2;
            acc        <= '0;
            sayac      <= CW'(XLEN - 1);
          end
        end
        HESAPLA: begin
          acc      <= {toplam, acc[XLEN-1:1]};
          carpan_q <= {acc[0], carpan_q[XLEN-1:1]};
          sayac    <= sayac - 1'b1;
        end
        DUZELT: begin
          sonuc_o <= (islem_q == ISLEM_MUL) ? urun[XLEN-1:0] : urun[2*XLEN-1:XLEN];
          bitti_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mesgul_o = (durum != BOS);

endmodule
